// File: rtl/dino_motion_ctrl.sv
// Per-frame motion and animation controller for the T-rex sprite: jump physics,
// ducking and leg-swap cadence. Optional macro DINO_FASTFALL_EN adds fast fall while ducking in the air.
module dino_motion_ctrl #(
  parameter logic [9:0] DINO_X   = 10'd60,
  parameter logic [8:0] GROUND_Y = 9'd300,
  parameter logic [8:0] DUCK_OFS = 9'd34,
  parameter logic [5:0] JUMP_V   = 6'd20,
  parameter logic [2:0] GRAVITY  = 3'd1,
  parameter logic [3:0] ANIM_DIV = 4'd6
`ifdef DINO_FASTFALL_EN
  ,
  parameter logic [2:0] FAST_FALL = 3'd3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       jump_btn,
  input  logic       duck_btn,
  output logic [9:0] DinoX,
  output logic [8:0] DinoY,
  output logic [3:0] AnimateSel,
  output logic       airborne
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DUCK = 3'd2,
    ST_JUMP = 3'd3,
    ST_DEAD = 3'd4
  } state_t;

  localparam logic [3:0] SEL_DEFAULT = 4'b0000;
  localparam logic [3:0] SEL_DEAD    = 4'b0001;
  localparam logic [3:0] SEL_RUN_L   = 4'b0011;
  localparam logic [3:0] SEL_RUN_R   = 4'b0111;
  localparam logic [3:0] SEL_DUCK_L  = 4'b0010;
  localparam logic [3:0] SEL_DUCK_R  = 4'b1011;

  localparam logic signed [10:0] GND_Y_S    = $signed({2'b00, GROUND_Y});
  localparam logic signed [7:0]  JUMP_VEL_S = -$signed({2'b00, JUMP_V});
  localparam logic signed [7:0]  GRAV_S     = $signed({5'b00000, GRAVITY});
  localparam logic [8:0]         DUCK_Y     = GROUND_Y + DUCK_OFS;

  state_t             state_r, state_s;
  logic signed [10:0] y_r, y_s, y_sum_s;
  logic signed [7:0]  vel_r, vel_s, vel_sum_s;
  logic [3:0]         cnt_r, cnt_s;
  logic               phase_r, phase_s;
  logic [8:0]         dino_y_r, dino_y_s;
  logic [3:0]         anim_r, anim_s;
  logic               air_r, air_s;

  assign DinoX      = DINO_X;
  assign DinoY      = dino_y_r;
  assign AnimateSel = anim_r;
  assign airborne   = air_r;

  // State, physics and registered sprite outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      y_r      <= GND_Y_S;
      vel_r    <= 8'sd0;
      cnt_r    <= 4'd0;
      phase_r  <= 1'b0;
      dino_y_r <= GROUND_Y;
      anim_r   <= SEL_DEFAULT;
      air_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      y_r      <= y_s;
      vel_r    <= vel_s;
      cnt_r    <= cnt_s;
      phase_r  <= phase_s;
      dino_y_r <= dino_y_s;
      anim_r   <= anim_s;
      air_r    <= air_s;
    end
  end

  // Next-state, jump physics and leg-phase update.
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    vel_s   = vel_r;
    cnt_s   = cnt_r;
    phase_s = phase_r;

    y_sum_s = y_r + $signed({{3{vel_r[7]}}, vel_r});
`ifdef DINO_FASTFALL_EN
    vel_sum_s = vel_r + GRAV_S + (duck_btn ? $signed({5'b00000, FAST_FALL}) : 8'sd0);
`else
    vel_sum_s = vel_r + GRAV_S;
`endif

    if (game_over && (state_r == ST_RUN || state_r == ST_DUCK || state_r == ST_JUMP)) begin
      state_s = ST_DEAD;
    end else if (game_start && (state_r == ST_IDLE || state_r == ST_DEAD)) begin
      state_s = ST_RUN;
      y_s     = GND_Y_S;
      vel_s   = 8'sd0;
      cnt_s   = 4'd0;
      phase_s = 1'b0;
    end else if (frame_tick) begin
      if (state_r == ST_RUN || state_r == ST_DUCK) begin
        if (cnt_r == ANIM_DIV - 4'd1) begin
          cnt_s   = 4'd0;
          phase_s = ~phase_r;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end else begin
        cnt_s = cnt_r;
      end

      case (state_r)
        ST_RUN: begin
          if (jump_btn) begin
            state_s = ST_JUMP;
            vel_s   = JUMP_VEL_S;
          end else if (duck_btn) begin
            state_s = ST_DUCK;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DUCK: begin
          if (jump_btn) begin
            state_s = ST_JUMP;
            vel_s   = JUMP_VEL_S;
          end else if (!duck_btn) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DUCK;
          end
        end
        ST_JUMP: begin
          // Landing consumes this tick, so a held jump re-launches on the next one.
          if (y_sum_s <= 11'sd0) begin
            y_s   = 11'sd0;
            vel_s = 8'sd0;
          end else if (y_sum_s >= GND_Y_S) begin
            y_s     = GND_Y_S;
            vel_s   = 8'sd0;
            state_s = duck_btn ? ST_DUCK : ST_RUN;
          end else begin
            y_s   = y_sum_s;
            vel_s = vel_sum_s;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Sprite select and Y for the state being entered.
  always_comb begin
    dino_y_s = GROUND_Y;
    anim_s   = SEL_DEFAULT;
    air_s    = 1'b0;
    case (state_s)
      ST_IDLE: begin
        dino_y_s = GROUND_Y;
        anim_s   = SEL_DEFAULT;
      end
      ST_RUN: begin
        dino_y_s = GROUND_Y;
        anim_s   = phase_s ? SEL_RUN_R : SEL_RUN_L;
      end
      ST_DUCK: begin
        dino_y_s = DUCK_Y;
        anim_s   = phase_s ? SEL_DUCK_R : SEL_DUCK_L;
      end
      ST_JUMP: begin
        dino_y_s = y_s[8:0];
        anim_s   = SEL_DEFAULT;
        air_s    = 1'b1;
      end
      ST_DEAD: begin
        dino_y_s = dino_y_r;
        anim_s   = SEL_DEAD;
      end
      default: begin
        dino_y_s = GROUND_Y;
        anim_s   = SEL_DEFAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Randomized and directed bench for dino_motion_ctrl against an integer-arithmetic
// reference of the motion rules.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, game_start, game_over, jump_btn, duck_btn;
  logic [9:0] DinoX;
  logic [8:0] DinoY;
  logic [3:0] AnimateSel;
  logic       airborne;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: mode 0 idle, 1 run, 2 duck, 3 jump, 4 dead
  int m_mode, m_y, m_vel, m_cnt, m_ph, m_disp;

  dino_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
    .game_over(game_over), .jump_btn(jump_btn), .duck_btn(duck_btn),
    .DinoX(DinoX), .DinoY(DinoY), .AnimateSel(AnimateSel), .airborne(airborne)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_anim();
    case (m_mode)
      1: return m_ph ? 7 : 3;
      2: return m_ph ? 11 : 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_update(input bit r, input bit ts, input bit gs, input bit go,
                              input bit jb, input bit db);
    int ny;
    bool_blk: begin end
    if (r) begin
      m_mode = 0; m_y = 300; m_vel = 0; m_cnt = 0; m_ph = 0;
    end else if (go && m_mode >= 1 && m_mode <= 3) begin
      m_mode = 4;
    end else if (gs && (m_mode == 0 || m_mode == 4)) begin
      m_mode = 1; m_y = 300; m_vel = 0; m_cnt = 0; m_ph = 0;
    end else if (ts) begin
      if (m_mode == 1 || m_mode == 2) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 6) begin m_cnt = 0; m_ph = 1 - m_ph; end
      end
      if (m_mode == 1 || m_mode == 2) begin
        if (jb) begin m_mode = 3; m_vel = -20; end
        else if (db) m_mode = 2;
        else m_mode = 1;
      end else if (m_mode == 3) begin
        ny = m_y + m_vel;
        if (ny <= 0) begin m_y = 0; m_vel = 0; end
        else if (ny >= 300) begin m_y = 300; m_vel = 0; m_mode = db ? 2 : 1; end
        else begin
          m_y = ny;
`ifdef DINO_FASTFALL_EN
          m_vel = m_vel + 1 + (db ? 3 : 0);
`else
          m_vel = m_vel + 1;
`endif
        end
      end
    end
    if (m_mode == 2) m_disp = 334;
    else if (m_mode == 3) m_disp = m_y;
    else if (m_mode != 4) m_disp = 300;
  endtask

  task automatic step(input bit r, input bit ts, input bit gs, input bit go,
                      input bit jb, input bit db);
    rst = r; frame_tick = ts; game_start = gs; game_over = go;
    jump_btn = jb; duck_btn = db;
    @(posedge clk);
    model_update(r, ts, gs, go, jb, db);
    #1;
    chk("dino_x", int'(DinoX), 60);
    chk("dino_y", int'(DinoY), m_disp);
    chk("anim_sel", int'(AnimateSel), exp_anim());
    chk("airborne", int'(airborne), (m_mode == 3) ? 1 : 0);
  endtask

  initial begin
    int ylist[3];
    int apex, land, frozen;
    bit jb, db, hit;
    ylist[0] = 280; ylist[1] = 261; ylist[2] = 243;
    rst = 1'b1; frame_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
    jump_btn = 1'b0; duck_btn = 1'b0;
    m_mode = 0; m_y = 300; m_vel = 0; m_cnt = 0; m_ph = 0; m_disp = 300;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0);
    chk("reset_y", int'(DinoY), 300);
    chk("reset_anim", int'(AnimateSel), 0);
    chk("reset_air", int'(airborne), 0);

    step(0, 0, 1, 0, 0, 0);
    chk("start_anim", int'(AnimateSel), 3);
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("leg_phase", int'(AnimateSel), (i < 6) ? 3 : 7);
      chk("run_y", int'(DinoY), 300);
    end

    // single jump with default physics
    step(0, 1, 0, 0, 1, 0);
    apex = 999; land = 0;
    for (int t = 1; t <= 60; t++) begin
      step(0, 1, 0, 0, 0, 0);
      if (t <= 3) chk("jump_rise", int'(DinoY), ylist[t-1]);
      if (int'(DinoY) < apex) apex = int'(DinoY);
      if (land == 0 && !airborne) land = t;
    end
    chk("jump_apex", apex, 90);
    chk("jump_land_tick", land, 41);

    step(0, 1, 0, 0, 0, 1);
    chk("duck_y", int'(DinoY), 334);
    chk("duck_anim_code", (AnimateSel == 4'b0010 || AnimateSel == 4'b1011) ? 1 : 0, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("duck_release_y", int'(DinoY), 300);

    // game over while rising, coinciding with a tick
    step(0, 1, 0, 0, 1, 0);
    hit = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (!hit) begin
        step(0, 1, 0, 0, 0, 0);
        if (int'(DinoY) <= 150) hit = 1'b1;
      end
    end
    frozen = int'(DinoY);
    chk("reached_150", hit, 1);
    step(0, 1, 0, 1, 0, 0);
    chk("dead_anim", int'(AnimateSel), 1);
    chk("dead_y", int'(DinoY), frozen);
    for (int t = 0; t < 3; t++) begin
      step(0, 1, 0, 0, 1, 1);
      chk("dead_frozen_y", int'(DinoY), frozen);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("restart_y", int'(DinoY), 300);
    chk("restart_anim", int'(AnimateSel), 3);

    step(0, 0, 1, 1, 0, 0);
    chk("over_beats_start", int'(AnimateSel), 1);

    // duck held from the apex
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    for (int t = 1; t <= 20; t++) step(0, 1, 0, 0, 0, 0);
    chk("apex_y", int'(DinoY), 90);
    land = 0;
    for (int k = 1; k <= 30; k++) begin
      step(0, 1, 0, 0, 0, 1);
      if (land == 0 && !airborne) land = k;
    end
`ifdef DINO_FASTFALL_EN
    chk("duck_fall_ticks", land, 11);
`else
    chk("duck_fall_ticks", land, 21);
`endif
    chk("duck_land_y", int'(DinoY), 334);

    // randomized play
    jb = 1'b0; db = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) jb = ~jb;
      if ($urandom_range(0, 7) == 0) db = ~db;
      step($urandom_range(0, 511) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, jb, db);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
